// File: rtl/lvds_seq_if.sv
// lvds_seq_if: word stream in, lock/pass/error status out for one lvds_seq_checker lane; SEQ_CHECK_BITERR_EN adds bit_err_count
interface lvds_seq_if #(
  parameter int DATA_W = 8,
  parameter int ERR_W  = 16
);
  logic              data_valid;
  logic [DATA_W-1:0] data_in;
  logic              prev_pass;
  logic              clear;
  logic              locked;
  logic              pass;
  logic              err_pulse;
  logic [ERR_W-1:0]  err_count;
`ifdef SEQ_CHECK_BITERR_EN
  logic [ERR_W+$clog2(DATA_W+1)-1:0] bit_err_count;
  modport master (output data_valid, data_in, prev_pass, clear, input locked, pass, err_pulse, err_count, bit_err_count);
  modport slave (input data_valid, data_in, prev_pass, clear, output locked, pass, err_pulse, err_count, bit_err_count);
`else
  modport master (output data_valid, data_in, prev_pass, clear, input locked, pass, err_pulse, err_count);
  modport slave (input data_valid, data_in, prev_pass, clear, output locked, pass, err_pulse, err_count);
`endif
endinterface

// File: rtl/lvds_seq_checker.sv
// lvds_seq_checker: arithmetic-sequence checker with lock FSM and saturating error count; SEQ_CHECK_BITERR_EN adds bit_err_count
module lvds_seq_checker #(
  parameter int DATA_W   = 8,
  parameter int STRIDE   = 1,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 4,
  parameter int ERR_W    = 16
) (
  input logic      clk,
  input logic      rst_n,
  lvds_seq_if.slave bus
);
  localparam int RUN_MAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
  localparam int RUN_W = $clog2(RUN_MAX + 1);
  localparam logic [DATA_W-1:0] STEP = DATA_W'(STRIDE);
  typedef enum logic {SEARCH, LOCKED} state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] expected_q, expected_d;
  logic [RUN_W-1:0]  run_q, run_d, run_inc;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              seeded_q, seeded_d;
  logic              last_ok_q, last_ok_d;
  logic              pulse_q, pulse_d;
  logic              hit, lock_hit, loss_hit;
  assign hit      = bus.data_in == expected_q;
  assign run_inc  = run_q + RUN_W'(1);
  assign lock_hit = seeded_q && hit && run_inc == RUN_W'(LOCK_CNT);
  assign loss_hit = !hit && run_inc == RUN_W'(LOSS_CNT);
  // The locking word is itself a match, so the lane reports good from the lock edge on.
  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    run_d      = run_q;
    seeded_d   = seeded_q;
    last_ok_d  = last_ok_q;
    err_d      = err_q;
    pulse_d    = 1'b0;
    if (bus.data_valid && state_q == SEARCH) begin
      state_d    = lock_hit ? LOCKED : SEARCH;
      expected_d = bus.data_in + STEP;
      run_d      = (seeded_q && hit && !lock_hit) ? run_inc : '0;
      seeded_d   = 1'b1;
      last_ok_d  = lock_hit ? 1'b1 : last_ok_q;
    end else if (bus.data_valid) begin
      state_d    = loss_hit ? SEARCH : LOCKED;
      expected_d = loss_hit ? bus.data_in + STEP : expected_q + STEP;
      run_d      = (hit || loss_hit) ? '0 : run_inc;
      last_ok_d  = hit;
      pulse_d    = !hit;
      err_d      = (!hit && !(&err_q)) ? err_q + ERR_W'(1) : err_q;
    end
    if (bus.clear) err_d = '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SEARCH;
      expected_q <= '0;
      run_q      <= '0;
      seeded_q   <= 1'b0;
      last_ok_q  <= 1'b0;
      err_q      <= '0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      run_q      <= run_d;
      seeded_q   <= seeded_d;
      last_ok_q  <= last_ok_d;
      err_q      <= err_d;
      pulse_q    <= pulse_d;
    end
  end
  assign bus.locked    = state_q == LOCKED;
  assign bus.pass      = (state_q == LOCKED) & last_ok_q & bus.prev_pass;
  assign bus.err_pulse = pulse_q;
  assign bus.err_count = err_q;
`ifdef SEQ_CHECK_BITERR_EN
  localparam int BIT_W = ERR_W + $clog2(DATA_W + 1);
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [BIT_W:0]   bit_sum;
  always_comb begin
    bit_sum = {1'b0, bit_q} + (BIT_W+1)'($countones(bus.data_in ^ expected_q));
    bit_d   = bus.clear ? '0 : (bus.data_valid && state_q == LOCKED) ? (bit_sum[BIT_W] ? '1 : bit_sum[BIT_W-1:0]) : bit_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bit_q <= '0;
    else bit_q <= bit_d;
  end
  assign bus.bit_err_count = bit_q;
`endif
endmodule

// File: tb/tb_lvds_seq_checker.sv
// tb_lvds_seq_checker: randomized directed bench against a word-level reference model for lvds_seq_checker
module tb_lvds_seq_checker;
  logic clk = 1'b0;
  logic rst_n;
  logic pp;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  lvds_seq_if #(.DATA_W(8), .ERR_W(16)) ia ();
  lvds_seq_if #(.DATA_W(8), .ERR_W(16)) ib ();
  lvds_seq_if #(.DATA_W(8), .ERR_W(4))  isat ();
  assign ia.prev_pass   = pp;
  assign ib.prev_pass   = ia.pass;
  assign isat.prev_pass = 1'b1;
  lvds_seq_checker #(.DATA_W(8), .STRIDE(1), .LOCK_CNT(4), .LOSS_CNT(4), .ERR_W(16)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  lvds_seq_checker #(.DATA_W(8), .STRIDE(1), .LOCK_CNT(4), .LOSS_CNT(4), .ERR_W(16)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  lvds_seq_checker #(.DATA_W(8), .STRIDE(1), .LOCK_CNT(4), .LOSS_CNT(4), .ERR_W(4))  u_s (.clk(clk), .rst_n(rst_n), .bus(isat));
  // Reference model: sequential-streak view of the link.
  bit     m_locked, m_seeded, m_ok, m_pulse;
  int     m_prev, m_streak, m_exp, m_bad;
  longint m_err, m_bit;
  task automatic model_reset();
    m_locked = 0; m_seeded = 0; m_ok = 0; m_pulse = 0;
    m_prev = 0; m_streak = 0; m_exp = 0; m_bad = 0; m_err = 0; m_bit = 0;
  endtask
  task automatic model_step(bit v, int d, bit clr);
    int pc;
    m_pulse = 0;
    if (v && !m_locked) begin
      m_streak = (m_seeded && d == (m_prev + 1) % 256) ? m_streak + 1 : 0;
      m_prev = d;
      m_seeded = 1;
      if (m_streak == 4) begin
        m_locked = 1; m_exp = (d + 1) % 256; m_ok = 1; m_bad = 0;
      end
    end else if (v) begin
      pc = 0;
      for (int b = 0; b < 8; b++) pc += ((d ^ m_exp) >> b) & 1;
      m_bit += pc;
      m_ok = (d == m_exp);
      m_pulse = !m_ok;
      m_err += m_ok ? 0 : 1;
      m_bad = m_ok ? 0 : m_bad + 1;
      m_exp = (m_exp + 1) % 256;
      if (m_bad == 4) begin
        m_locked = 0; m_prev = d; m_streak = 0;
      end
    end
    if (clr) begin m_err = 0; m_bit = 0; end
  endtask
  function automatic longint sat(longint v, longint m);
    return v > m ? m : v;
  endfunction
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("locked_a", 64'(ia.locked), 64'(m_locked));
    chk("locked_b", 64'(ib.locked), 64'(m_locked));
    chk("locked_s", 64'(isat.locked), 64'(m_locked));
    chk("pass_a", 64'(ia.pass), 64'(m_locked & m_ok & pp));
    chk("pass_b", 64'(ib.pass), 64'(m_locked & m_ok & pp));
    chk("err_pulse", 64'(ia.err_pulse), 64'(m_pulse));
    chk("err_count_a", 64'(ia.err_count), 64'(sat(m_err, 65535)));
    chk("err_count_s", 64'(isat.err_count), 64'(sat(m_err, 15)));
`ifdef SEQ_CHECK_BITERR_EN
    chk("bit_err_count", 64'(ia.bit_err_count), 64'(sat(m_bit, (64'd1 << 20) - 1)));
`endif
  endtask
  task automatic drive(bit v, int d, bit clr);
    ia.data_valid = v;   ia.data_in = d[7:0];   ia.clear = clr;
    ib.data_valid = v;   ib.data_in = d[7:0];   ib.clear = clr;
    isat.data_valid = v; isat.data_in = d[7:0]; isat.clear = clr;
  endtask
  task automatic step(bit v, int d, bit clr);
    drive(v, d, clr);
    @(posedge clk);
    model_step(v, d, clr);
    #1 check_all();
    @(negedge clk);
  endtask
  task automatic run_seq(int start, int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) step(0, int'($urandom_range(0, 255)), 0);
      step(1, (start + i) % 256, 0);
    end
  endtask
  task automatic bad_word();
    int b;
    do b = int'($urandom_range(0, 255)); while (b == m_exp);
    step(1, b, 0);
  endtask
  initial begin
    int seq;
    rst_n = 1'b0;
    pp = 1'b1;
    drive(0, 0, 0);
    model_reset();
    #3;
    chk("rst_locked", 64'(ia.locked), 64'd0);
    chk("rst_pass", 64'(ia.pass), 64'd0);
    chk("rst_pulse", 64'(ia.err_pulse), 64'd0);
    chk("rst_err", 64'(ia.err_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      step(1, i, 0);
      if (i == 3) chk("lock_after_4", 64'(ia.locked), 64'd0);
      if (i == 4) begin
        chk("lock_after_5", 64'(ia.locked), 64'd1);
        chk("pass_at_lock", 64'(ia.pass), 64'd1);
      end
    end
    chk("clean_err", 64'(ia.err_count), 64'd0);
    for (int i = 0; i < 3; i++) step(0, int'($urandom_range(0, 255)), 0);
    run_seq(17, 'h104 - 17);
    chk("wrap_err", 64'(ia.err_count), 64'd0);
    run_seq(4, 'h20 - 4);
    step(1, 'h5A, 0);
    chk("corrupt_pulse", 64'(ia.err_pulse), 64'd1);
    chk("corrupt_err", 64'(ia.err_count), 64'd1);
    chk("corrupt_locked", 64'(ia.locked), 64'd1);
    chk("corrupt_pass", 64'(ia.pass), 64'd0);
    step(1, 'h21, 0);
    chk("recover_pass", 64'(ia.pass), 64'd1);
    chk("recover_pulse", 64'(ia.err_pulse), 64'd0);
    run_seq('h22, 'h30 - 'h22);
    step(0, 0, 1);
    for (int i = 0; i < 4; i++) bad_word();
    chk("loss_err", 64'(ia.err_count), 64'd4);
    chk("loss_locked", 64'(ia.locked), 64'd0);
    seq = 'h34;
    for (int i = 0; i < 5; i++) begin
      step(1, seq + i, 0);
      if (i == 3) chk("relock_after_4", 64'(ia.locked), 64'd0);
    end
    chk("relock_after_5", 64'(ia.locked), 64'd1);
    step(0, 0, 1);
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++) bad_word();
      seq = int'($urandom_range(0, 255));
      for (int i = 0; i < 5; i++) step(1, (seq + i) % 256, 0);
    end
    chk("sat_err_a", 64'(ia.err_count), 64'd20);
    chk("sat_err_s", 64'(isat.err_count), 64'd15);
    bad_word();
    step(1, m_exp, 0);
    drive(1, (m_exp + 7) % 256, 1);
    @(posedge clk);
    model_step(1, (m_exp + 7) % 256, 1);
    #1 check_all();
    chk("clear_vs_err_a", 64'(ia.err_count), 64'd0);
    chk("clear_vs_err_s", 64'(isat.err_count), 64'd0);
    @(negedge clk);
    step(1, m_exp, 0);
    pp = 1'b0;
    for (int i = 0; i < 4; i++) step(1, m_exp, 0);
    chk("chain_locked", 64'(ib.locked), 64'd1);
    chk("chain_pass_a", 64'(ia.pass), 64'd0);
    chk("chain_pass_b", 64'(ib.pass), 64'd0);
    pp = 1'b1;
    #1;
    chk("pp_comb_a", 64'(ia.pass), 64'd1);
    chk("pp_comb_b", 64'(ib.pass), 64'd1);
    step(0, 0, 1);
    for (int i = 0; i < 260 && m_exp != 'h20; i++) step(1, m_exp, 0);
    step(1, 'h2F, 0);
`ifdef SEQ_CHECK_BITERR_EN
    chk("bit_err_4", 64'(ia.bit_err_count), 64'd4);
`endif
    step(1, 'h21, 0);
    step(1, 'h22, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_locked", 64'(ia.locked), 64'd0);
    chk("arst_pass", 64'(ia.pass), 64'd0);
    chk("arst_err", 64'(ia.err_count), 64'd0);
    chk("arst_pass_b", 64'(ib.pass), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run_seq('h50, 5);
    chk("post_rst_lock", 64'(ia.locked), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lvds_seq_checker.md
# lvds_seq_checker

Parametrised receive-side sequence checker for the LVDS loopback path. Each valid word is compared against the expected arithmetic sequence (previous + STRIDE, modulo 2^DATA_W). A lock state machine decides when the link is trusted, and a saturating error counter is kept. Instances chain through `prev_pass`/`pass` so one `pass` summarises every lane.

## Interface
- `DATA_W`, 8: word width in bits.
- `STRIDE`, 1: expected increment between consecutive valid words, taken modulo 2^DATA_W.
- `LOCK_CNT`, 4: consecutive good words required to lock (≥1).
- `LOSS_CNT`, 4: consecutive bad words, while locked, that drop lock (≥1).
- `ERR_W`, 16: error counter width.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `data_valid` in 1: `data_in` is a valid word this cycle.
- `data_in` in DATA_W: received word.
- `prev_pass` in 1: `pass` from the upstream lane; tie to 1 on the first lane.
- `clear` in 1: synchronous clear of the error counters.
- `locked` out 1: FSM is in LOCKED.
- `pass` out 1: this lane is good AND `prev_pass`.
- `err_pulse` out 1: one-cycle pulse on each mismatched word while LOCKED.
- `err_count` out ERR_W: saturating count of mismatched words while LOCKED.

## Operation
- Registers: `expected` (DATA_W), `run` counter, `state`, `err_count`, and `last_ok` (1 bit).
- **SEARCH** (reset state). On each valid word:
  - `expected <= data_in + STRIDE`.
  - If `data_in == expected` and `seeded`, increment `run`; otherwise set `run` to 0.
  - `seeded` is set by the first valid word after reset.
  - When `run` reaches LOCK_CNT, go to LOCKED and set `run` to 0.
- **LOCKED**. `expected` free-runs on every valid word: `expected <= expected + STRIDE`. It is not reseeded from data, so one corrupted word counts as exactly one error.
  - On a match, set `run` to 0 and `last_ok` to 1.
  - On a mismatch: increment `err_count` (saturating at all-ones), pulse `err_pulse`, set `last_ok` to 0, and increment `run`.
  - When `run` reaches LOSS_CNT, go to SEARCH, set `run` to 0, and set `expected <= data_in + STRIDE` (reseed).
- While `data_valid` = 0, all state holds and `err_pulse` = 0.
- `pass` = `locked & last_ok & prev_pass`. This is combinational from registered signals and `prev_pass`.
- `clear`:
  - Sets `err_count` (and the bit counter, if present) to 0.
  - Takes priority over a simultaneous increment.
  - Does not affect `state`, `expected` or `run`.
- Sum widths are DATA_W; wrap-around (e.g. 0xFF + 1 → 0x00 at DATA_W=8) is a match, not an error.

## Timing
- Reset values: `locked` = 0, `pass` = 0, `err_pulse` = 0, `err_count` = 0, `expected` = 0, `run` = 0, `seeded` = 0, `last_ok` = 0.
- Latency: the word sampled at edge N updates `locked`/`err_count`/`err_pulse`/`last_ok`, visible after edge N.
- Lock time: with a clean stream from reset, `locked` rises after the (LOCK_CNT+1)th valid word. The first word only seeds.
- Drop time: `locked` falls on the edge that samples the LOSS_CNTth consecutive bad word. That word also counts as an error.
- `rst_n` asserted mid-operation clears everything immediately, without waiting for a clock. Deassertion is synchronised externally.
- `prev_pass` change propagates to `pass` in the same cycle.

## Configuration
- `SEQ_CHECK_BITERR_EN`, when defined:
  - Adds output `bit_err_count` [ERR_W+$clog2(DATA_W+1)-1:0].
  - While LOCKED, it accumulates popcount(`data_in ^ expected`) per valid word, saturating at all-ones.
  - It is cleared by `clear` and by reset.
- When undefined: the port and logic are absent. All other behaviour is identical.

## Test plan
- **Clean lock:** reset; DATA_W=8, STRIDE=1; stream 0x00..0x10 with `data_valid`=1.
  - Required: `locked` = 1 after the 5th word, `pass` = 1, `err_count` = 0.
- **Wrap-around:** stream 0xFC..0x03 while locked.
  - Required: no `err_pulse`, `err_count` stays 0.
- **Single corruption:** while locked, replace 0x20 with 0x5A.
  - Required: exactly one `err_pulse`, `err_count` = 1, `locked` stays 1.
  - `pass` = 0 for one cycle, then 1 on the next good word.
- **Loss of lock:** while locked, send 4 consecutive random bad words.
  - Required: `err_count` = 4, `locked` falls after the 4th, and relock needs 5 further sequential words.
- **Clear/saturation:** ERR_W=4; force 20 errors, toggling lock with clean runs.
  - Required: `err_count` stops at 15. `clear` asserted together with a mismatch gives 0.
- **Chain/reset:** two lanes chained; hold `prev_pass`=0.
  - Required: `pass` = 0 despite lock.
  - Assert `rst_n`=0 mid-stream: required `locked`=`pass`=`err_count`=0 before the next clock edge.
  - With `SEQ_CHECK_BITERR_EN` defined, 0x20 → 0x2F gives `bit_err_count` = 4.
